// File: rtl/rx_frame_ram_writer.sv
// Packs an Avalon-ST byte stream into little-endian 32-bit frame-RAM words.
// Define RX_LEN_HEADER_EN to add a {err, len} header word at BASE_ADDR after each frame.
module rx_frame_ram_writer #(
  parameter int ADDR_W    = 10,
  parameter int DEPTH     = 1024,
  parameter int BASE_ADDR = 0,
  parameter int LEN_W     = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  input  logic              in_sop,
  input  logic              in_eop,
  output logic              in_ready,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_address,
  output logic [3:0]        ram_byteenable,
  output logic [31:0]       ram_writedata,
  output logic              frame_done,
  output logic [LEN_W-1:0]  frame_len,
  output logic              frame_err,
  input  logic              cpu_ack
);

`ifdef RX_LEN_HEADER_EN
  localparam int HDR_WORDS = 1;
  typedef enum logic [2:0] {IDLE, FILL, FLUSH, HDR, DONE} state_t;
`else
  localparam int HDR_WORDS = 0;
  typedef enum logic [2:0] {IDLE, FILL, FLUSH, DONE} state_t;
`endif

  localparam logic [LEN_W-1:0]  CAP      = LEN_W'((DEPTH - HDR_WORDS) * 4);
  localparam logic [ADDR_W-1:0] PAY_BASE = ADDR_W'(BASE_ADDR + HDR_WORDS);

  state_t state, state_next;

  logic [LEN_W-1:0] cnt;
  logic [23:0]      word_buf;
  logic             err;

  logic             accept, start, store, abort, room;
  logic [LEN_W-1:0] base_cnt;
  logic [1:0]       lane;
  logic [31:0]      merged, partial;
  logic [3:0]       merged_be, partial_be;

  assign accept   = in_valid & in_ready;
  assign start    = accept & in_sop & (state == IDLE);
  assign store    = start | (accept & ~in_sop & (state == FILL));
  assign abort    = accept & in_sop & (state == FILL);
  // cnt still holds the previous frame's length while idle, so a new frame counts from zero
  assign base_cnt = start ? '0 : cnt;
  assign room     = base_cnt < CAP;
  assign lane     = base_cnt[1:0];
  assign frame_len = cnt;
  assign frame_err = err;

  // merged: word including the incoming byte; partial: lanes already buffered (for aborts)
  always_comb begin
    merged     = 32'h0;
    merged_be  = 4'h0;
    partial    = 32'h0;
    partial_be = 4'h0;
    case (lane)
      2'd0: begin
        merged    = {24'h0, in_data};
        merged_be = 4'h1;
      end
      2'd1: begin
        merged     = {16'h0, in_data, word_buf[7:0]};
        merged_be  = 4'h3;
        partial    = {24'h0, word_buf[7:0]};
        partial_be = 4'h1;
      end
      2'd2: begin
        merged     = {8'h0, in_data, word_buf[15:0]};
        merged_be  = 4'h7;
        partial    = {16'h0, word_buf[15:0]};
        partial_be = 4'h3;
      end
      default: begin
        merged     = {in_data, word_buf};
        merged_be  = 4'hF;
        partial    = {8'h0, word_buf};
        partial_be = 4'h7;
      end
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start) state_next = in_eop ? FLUSH : FILL;
      FILL:  if (accept && (in_sop || in_eop)) state_next = FLUSH;
`ifdef RX_LEN_HEADER_EN
      FLUSH: state_next = HDR;
      HDR:   state_next = DONE;
`else
      FLUSH: state_next = DONE;
`endif
      DONE:  if (cpu_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      in_ready       <= 1'b0;
      cnt            <= '0;
      word_buf       <= '0;
      err            <= 1'b0;
      ram_chipselect <= 1'b0;
      ram_write      <= 1'b0;
      ram_address    <= '0;
      ram_byteenable <= 4'h0;
      ram_writedata  <= 32'h0;
      frame_done     <= 1'b0;
    end else begin
      state          <= state_next;
      in_ready       <= (state_next == IDLE) || (state_next == FILL);
      frame_done     <= (state_next == DONE) && (state != DONE);
      ram_chipselect <= 1'b0;
      ram_write      <= 1'b0;

      if (start) err <= 1'b0;
      if (abort || (store && !room)) err <= 1'b1;

      if (store && room) begin
        cnt <= base_cnt + LEN_W'(1);
        case (lane)
          2'd0:    word_buf <= {16'h0, in_data};
          2'd1:    word_buf[15:8] <= in_data;
          2'd2:    word_buf[23:16] <= in_data;
          default: ;
        endcase
        if (lane == 2'd3 || in_eop) begin
          ram_chipselect <= 1'b1;
          ram_write      <= 1'b1;
          ram_address    <= PAY_BASE + ADDR_W'(base_cnt >> 2);
          ram_byteenable <= merged_be;
          ram_writedata  <= merged;
        end
      end

      // A full word before the aborting byte was already written, so only lanes 1..3 matter
      if (abort && lane != 2'd0) begin
        ram_chipselect <= 1'b1;
        ram_write      <= 1'b1;
        ram_address    <= PAY_BASE + ADDR_W'(cnt >> 2);
        ram_byteenable <= partial_be;
        ram_writedata  <= partial;
      end

`ifdef RX_LEN_HEADER_EN
      if (state == FLUSH) begin
        ram_chipselect <= 1'b1;
        ram_write      <= 1'b1;
        ram_address    <= ADDR_W'(BASE_ADDR);
        ram_byteenable <= 4'hF;
        ram_writedata  <= {err, {(31 - LEN_W){1'b0}}, cnt};
      end
`endif
    end
  end

endmodule

// File: tb/tb_rx_frame_ram_writer.sv
// Bench for rx_frame_ram_writer: directed and random frames checked against a
// byte-list reference model of packing, capacity and timing.
module tb_rx_frame_ram_writer;
  localparam int ADDR_W = 10, DEPTH = 1024, BASE_ADDR = 0, LEN_W = 13;
`ifdef RX_LEN_HEADER_EN
  localparam int HOFF = 1;
`else
  localparam int HOFF = 0;
`endif
  localparam int CAP = (DEPTH - HOFF) * 4;

  logic clk = 1'b0, reset = 1'b1;
  logic [7:0] in_data = 8'h0;
  logic in_valid = 1'b0, in_sop = 1'b0, in_eop = 1'b0, cpu_ack = 1'b0;
  logic in_ready, ram_chipselect, ram_write, frame_done, frame_err;
  logic [ADDR_W-1:0] ram_address;
  logic [3:0] ram_byteenable;
  logic [31:0] ram_writedata;
  logic [LEN_W-1:0] frame_len;

  typedef struct { logic [7:0] d; bit sop; bit eop; } beat_t;
  typedef struct { int cyc; logic [ADDR_W-1:0] addr; logic [31:0] data; logic [3:0] be; } wr_t;

  beat_t beats[$];
  int    beat_cyc[$];
  wr_t   wr_log[$];
  wr_t   exp_wr[$];
  int    done_log[$];
  wr_t   mon_w;
  int    exp_len, exp_done;
  bit    exp_err;
  int    cyc = 0, checks = 0, passed = 0, cs_bad = 0;

  rx_frame_ram_writer #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE_ADDR), .LEN_W(LEN_W)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_sop(in_sop), .in_eop(in_eop), .in_ready(in_ready),
    .ram_chipselect(ram_chipselect), .ram_write(ram_write), .ram_address(ram_address),
    .ram_byteenable(ram_byteenable), .ram_writedata(ram_writedata),
    .frame_done(frame_done), .frame_len(frame_len), .frame_err(frame_err), .cpu_ack(cpu_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ram_chipselect !== ram_write) cs_bad++;
    if (ram_write === 1'b1) begin
      mon_w.cyc = cyc; mon_w.addr = ram_address; mon_w.data = ram_writedata; mon_w.be = ram_byteenable;
      wr_log.push_back(mon_w);
    end
    if (frame_done === 1'b1) done_log.push_back(cyc);
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  function automatic beat_t mk(input logic [7:0] d, input bit sop, input bit eop);
    beat_t b;
    b.d = d; b.sop = sop; b.eop = eop;
    return b;
  endfunction

  task automatic clear_logs();
    wr_log.delete(); done_log.delete(); cs_bad = 0;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
    if (in_ready !== 1'b1) check_output("ready_timeout", in_ready, 1);
  endtask

  // Drives the beat list; expects to be called at posedge+1 and returns there
  task automatic apply_stimulus(input int max_gap);
    int gap;
    beat_cyc.delete();
    foreach (beats[i]) begin
      gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
      in_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
      wait_ready();
      in_valid = 1'b1; in_data = beats[i].d; in_sop = beats[i].sop; in_eop = beats[i].eop;
      beat_cyc.push_back(cyc);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  // Reference: collect stored bytes from the beat list, then slice into words
  task automatic build_expected();
    logic [7:0] stored[$];
    int full_cyc[$];
    bit in_frame, fin, keep;
    int term_c, nb;
    wr_t w;
    in_frame = 0; fin = 0; term_c = 0;
    exp_wr.delete(); exp_err = 0;
    for (int i = 0; i < beats.size() && !fin; i++) begin
      keep = 0;
      if (!in_frame) begin
        if (beats[i].sop) begin in_frame = 1; keep = 1; end
      end else if (beats[i].sop) begin
        exp_err = 1; fin = 1; term_c = beat_cyc[i];
      end else keep = 1;
      if (keep) begin
        if (stored.size() < CAP) begin
          stored.push_back(beats[i].d);
          if (stored.size() % 4 == 0) full_cyc.push_back(beat_cyc[i]);
        end else exp_err = 1;
        if (beats[i].eop) begin fin = 1; term_c = beat_cyc[i]; end
      end
    end
    exp_len = stored.size();
    for (int k = 0; k * 4 < stored.size(); k++) begin
      nb = stored.size() - 4 * k;
      if (nb > 4) nb = 4;
      w.addr = ADDR_W'(BASE_ADDR + HOFF + k);
      w.data = 32'h0;
      for (int j = 0; j < nb; j++) w.data = w.data | (32'(stored[4*k+j]) << (8 * j));
      w.be = 4'((1 << nb) - 1);
      w.cyc = (k < full_cyc.size()) ? full_cyc[k] + 1 : term_c + 1;
      exp_wr.push_back(w);
    end
`ifdef RX_LEN_HEADER_EN
    w.addr = ADDR_W'(BASE_ADDR);
    w.data = (32'(exp_err) << 31) | 32'(exp_len);
    w.be = 4'hF;
    w.cyc = term_c + 2;
    exp_wr.push_back(w);
`endif
    exp_done = term_c + 2 + HOFF;
  endtask

  task automatic check_frame(input string name);
    build_expected();
    repeat (6) @(posedge clk);
    @(negedge clk);
    check_output({name, ".nwr"}, wr_log.size(), exp_wr.size());
    for (int i = 0; i < wr_log.size() && i < exp_wr.size(); i++) begin
      check_output($sformatf("%s.addr[%0d]", name, i), 32'(wr_log[i].addr), 32'(exp_wr[i].addr));
      check_output($sformatf("%s.data[%0d]", name, i), wr_log[i].data, exp_wr[i].data);
      check_output($sformatf("%s.be[%0d]", name, i), 32'(wr_log[i].be), 32'(exp_wr[i].be));
      check_output($sformatf("%s.wcyc[%0d]", name, i), wr_log[i].cyc, exp_wr[i].cyc);
    end
    check_output({name, ".ndone"}, done_log.size(), 1);
    if (done_log.size() > 0) check_output({name, ".done_cyc"}, done_log[0], exp_done);
    check_output({name, ".len"}, 32'(frame_len), exp_len);
    check_output({name, ".err"}, 32'(frame_err), 32'(exp_err));
    check_output({name, ".ready_done"}, 32'(in_ready), 0);
    check_output({name, ".cs"}, cs_bad, 0);
    @(posedge clk); #1;
  endtask

  task automatic release_buffer(input string name);
    cpu_ack = 1'b1;
    @(posedge clk); #1;
    cpu_ack = 1'b0;
    @(negedge clk);
    check_output({name, ".ack_ready"}, 32'(in_ready), 1);
    @(posedge clk); #1;
    clear_logs();
  endtask

  task automatic check_all_zero(input string name);
    check_output({name, ".ready"}, 32'(in_ready), 0);
    check_output({name, ".cs"}, 32'(ram_chipselect), 0);
    check_output({name, ".wr"}, 32'(ram_write), 0);
    check_output({name, ".addr"}, 32'(ram_address), 0);
    check_output({name, ".be"}, 32'(ram_byteenable), 0);
    check_output({name, ".wdata"}, ram_writedata, 0);
    check_output({name, ".done"}, 32'(frame_done), 0);
    check_output({name, ".len"}, 32'(frame_len), 0);
    check_output({name, ".err"}, 32'(frame_err), 0);
  endtask

  task automatic random_frame(input int len);
    beats.delete();
    for (int i = 0; i < len; i++) beats.push_back(mk(8'($urandom), i == 0, i == len - 1));
  endtask

  initial begin
    // Reset state and release timing
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("rst");
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check_output("rst.ready_drop_cycle", 32'(in_ready), 0);
    @(posedge clk); #1;
    @(negedge clk);
    check_output("rst.ready_after", 32'(in_ready), 1);
    @(posedge clk); #1;
    clear_logs();

    // 6-byte frame 11..66
    beats.delete();
    for (int i = 1; i <= 6; i++) beats.push_back(mk(8'(i * 8'h11), i == 1, i == 6));
    apply_stimulus(0);
    check_frame("six");
    if (wr_log.size() >= 2) begin
      check_output("six.w0_const", wr_log[0].data, 32'h44332211);
      check_output("six.w1_const", wr_log[1].data, 32'h00006655);
      check_output("six.a1_const", 32'(wr_log[1].addr), 32'(HOFF + 1));
      check_output("six.be1_const", 32'(wr_log[1].be), 32'h3);
    end
    release_buffer("six");

    // 1-byte frame, then hold DONE without cpu_ack
    beats.delete();
    beats.push_back(mk(8'hA5, 1, 1));
    apply_stimulus(0);
    check_frame("one");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_output($sformatf("hold.ready[%0d]", i), 32'(in_ready), 0);
      check_output($sformatf("hold.len[%0d]", i), 32'(frame_len), 1);
      @(posedge clk); #1;
    end
    check_output("hold.ndone", done_log.size(), 1);
    release_buffer("one");

    // Bytes without sop in IDLE, and cpu_ack outside DONE
    beats.delete();
    beats.push_back(mk(8'h12, 0, 0));
    beats.push_back(mk(8'h34, 0, 1));
    beats.push_back(mk(8'h56, 0, 0));
    apply_stimulus(0);
    cpu_ack = 1'b1;
    @(posedge clk); #1;
    cpu_ack = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_output("nosop.nwr", wr_log.size(), 0);
    check_output("nosop.ndone", done_log.size(), 0);
    check_output("nosop.ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    clear_logs();

    // Random frames with leading junk and idle gaps
    for (int f = 0; f < 5; f++) begin
      random_frame(int'($urandom_range(40, 1)));
      for (int j = int'($urandom_range(2, 0)); j > 0; j--) beats.push_front(mk(8'($urandom), 0, 0));
      apply_stimulus(1);
      check_frame($sformatf("rnd%0d", f));
      release_buffer("rnd");
    end

    // sop mid-frame after 5 bytes aborts
    random_frame(5);
    beats[4].eop = 0;
    beats.push_back(mk(8'($urandom), 1, 0));
    apply_stimulus(0);
    check_frame("abort");
    release_buffer("abort");

    // Oversized frame saturates at capacity
    random_frame(4100);
    apply_stimulus(0);
    check_frame("big");
    release_buffer("big");

    // Reset in the middle of a frame
    random_frame(7);
    beats[6].eop = 0;
    apply_stimulus(0);
    reset = 1'b1;
    @(posedge clk); #1;
    clear_logs();
    @(negedge clk);
    check_all_zero("midrst");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check_output("midrst.nwr", wr_log.size(), 0);
    check_output("midrst.ndone", done_log.size(), 0);
    check_output("midrst.ready", 32'(in_ready), 1);
    @(posedge clk); #1;

    random_frame(9);
    apply_stimulus(1);
    check_frame("post");
    release_buffer("post");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end
endmodule
